// File: rtl/soundgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soundgen_pkg
//  Description : Shared types and constant tables for the tt_um_soundgen
//                melody sequencer: FSM state encoding, song table entry
//                format, the melody itself and the pitch -> period table.
//  Macros      : none (SEQ_LOOP_EN is consumed by note_sequencer)
//  Revision    : 1.0 - initial release
// ============================================================================
package soundgen_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } seq_state_e;

    // One song table entry, packed as {pitch[3:0], dur[3:0]}.
    // pitch 0 is a rest; dur is the slot length in beats minus one.
    typedef struct packed {
        logic [3:0] pitch;
        logic [3:0] dur;
    } note_t;

    // Melody, played from index 0 upwards.
    localparam note_t SONG_ROM [16] = '{
        '{4'd5,  4'd0},
        '{4'd0,  4'd1},
        '{4'd8,  4'd0},
        '{4'd12, 4'd1},
        '{4'd10, 4'd0},
        '{4'd8,  4'd0},
        '{4'd5,  4'd1},
        '{4'd0,  4'd0},
        '{4'd3,  4'd0},
        '{4'd5,  4'd0},
        '{4'd6,  4'd1},
        '{4'd0,  4'd0},
        '{4'd8,  4'd0},
        '{4'd6,  4'd0},
        '{4'd5,  4'd0},
        '{4'd1,  4'd3}
    };

    // Half-period counts at a 10 MHz clock, C4 upwards. Entry 0 (rest) is 0.
    localparam logic [15:0] PERIOD_LUT [16] = '{
        16'd0,
        16'd19111, 16'd17026, 16'd15168, 16'd14317, 16'd12755,
        16'd11364, 16'd10124, 16'd9556,  16'd8513,  16'd7584,
        16'd7159,  16'd6378,  16'd5682,  16'd5062,  16'd4778
    };

endpackage : soundgen_pkg
`default_nettype wire

// File: rtl/note_period_lut.sv
`default_nettype none
// ============================================================================
//  Module      : note_period_lut
//  Description : Combinational pitch index -> tone half-period lookup.
//  Ports       : pitch_i  [3:0]          pitch index (0 = rest)
//                period_o [PERIOD_W-1:0] half-period count, 0 for a rest
//  Revision    : 1.0 - initial release
// ============================================================================
module note_period_lut
    import soundgen_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic [3:0]          pitch_i,
    output logic [PERIOD_W-1:0] period_o
);

    assign period_o = PERIOD_W'(PERIOD_LUT[pitch_i]);

endmodule : note_period_lut
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer
//  Description : Plays the fixed melody in soundgen_pkg::SONG_ROM by driving
//                the tone generator. Each step loads a pitch period, sounds
//                it, then leaves GAP_CYCLES of silence at the end of its slot.
//  Macros      : SEQ_LOOP_EN - when defined the melody repeats forever and
//                done never pulses; otherwise playback stops after the last
//                step with a one-cycle done pulse.
//  Ports       : clk, rst_n          clock, async active-low reset
//                start, stop         control pulses (stop has priority)
//                busy, done          status
//                tone_en             tone generator gate
//                tone_period         half-period count, 0 when silent/idle
//                tone_strobe         pulse on every period reload
//                note_idx [3:0]      step currently playing
//  Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import soundgen_pkg::*;
#(
    parameter int BEAT_DIV   = 1250000,
    parameter int GAP_CYCLES = 250000,
    parameter int SONG_LEN   = 16,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic                tone_en,
    output logic [PERIOD_W-1:0] tone_period,
    output logic                tone_strobe,
    output logic [3:0]          note_idx
);

    localparam int         SLOT_W   = $clog2(16 * BEAT_DIV);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LOAD   = LOAD;
    localparam logic [1:0] S_PLAY   = PLAY;
    localparam logic [3:0] LAST_STEP = 4'(SONG_LEN - 1);

    logic [1:0]          state_q,       state_d;
    logic [3:0]          step_q,        step_d;
    logic [SLOT_W-1:0]   slot_cnt_q,    slot_cnt_d;
    logic                busy_q,        busy_d;
    logic                done_q,        done_d;
    logic                tone_en_q,     tone_en_d;
    logic [PERIOD_W-1:0] tone_period_q, tone_period_d;
    logic                tone_strobe_q, tone_strobe_d;
    logic [3:0]          note_idx_q,    note_idx_d;

    note_t               w_note;
    logic [PERIOD_W-1:0] w_period;
    logic [31:0]         w_slot_len;
    logic                w_slot_end;
    logic                w_sound;

    // The step index is stable for a whole slot, so the table entry can be
    // read combinationally in both LOAD and PLAY.
    assign w_note = SONG_ROM[step_q];

    note_period_lut #(
        .PERIOD_W (PERIOD_W)
    ) u_lut (
        .pitch_i  (w_note.pitch),
        .period_o (w_period)
    );

    // slot_cnt_q is 0 during LOAD, so it equals the slot cycle index.
    // tone_en is registered: deciding at index k makes it visible at k+1,
    // giving exactly SLOT-GAP_CYCLES sounding cycles from index 1.
    assign w_slot_len = (32'(w_note.dur) + 32'd1) * 32'(BEAT_DIV);
    assign w_slot_end = (32'(slot_cnt_q) == (w_slot_len - 32'd1));
    assign w_sound    = (w_note.pitch != 4'd0) &&
                        (32'(slot_cnt_q) < (w_slot_len - 32'(GAP_CYCLES)));

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        slot_cnt_d    = slot_cnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        tone_en_d     = tone_en_q;
        tone_period_d = tone_period_q;
        tone_strobe_d = 1'b0;
        note_idx_d    = note_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d    = S_LOAD;
                    step_d     = 4'd0;
                    slot_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end

            S_LOAD: begin
                state_d       = S_PLAY;
                slot_cnt_d    = SLOT_W'(1);
                tone_period_d = w_period;
                tone_strobe_d = 1'b1;
                note_idx_d    = step_q;
                tone_en_d     = w_sound;
            end

            S_PLAY: begin
                tone_en_d = w_sound;
                if (w_slot_end) begin
                    if (step_q != LAST_STEP) begin
                        step_d     = 4'(step_q + 4'd1);
                        state_d    = S_LOAD;
                        slot_cnt_d = '0;
                    end else begin
`ifdef SEQ_LOOP_EN
                        step_d     = 4'd0;
                        state_d    = S_LOAD;
                        slot_cnt_d = '0;
`else
                        state_d       = S_IDLE;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        tone_en_d     = 1'b0;
                        tone_period_d = '0;
`endif
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above, including a coincident start.
        if (stop && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            slot_cnt_d    = '0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            tone_en_d     = 1'b0;
            tone_period_d = '0;
            tone_strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            step_q        <= 4'd0;
            slot_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tone_en_q     <= 1'b0;
            tone_period_q <= '0;
            tone_strobe_q <= 1'b0;
            note_idx_q    <= 4'd0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            slot_cnt_q    <= slot_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tone_en_q     <= tone_en_d;
            tone_period_q <= tone_period_d;
            tone_strobe_q <= tone_strobe_d;
            note_idx_q    <= note_idx_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign tone_en     = tone_en_q;
    assign tone_period = tone_period_q;
    assign tone_strobe = tone_strobe_q;
    assign note_idx    = note_idx_q;

endmodule : note_sequencer
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_sequencer
//  Description : Self-checking bench for note_sequencer with BEAT_DIV=8,
//                GAP_CYCLES=2, SONG_LEN=4. Expected output vectors
//                {busy, done, tone_en, tone_strobe, tone_period, note_idx}
//                are queued when stimulus is applied and compared cycle by
//                cycle. Honours SEQ_LOOP_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;
    import soundgen_pkg::*;

    localparam int BEAT_DIV   = 8;
    localparam int GAP_CYCLES = 2;
    localparam int SONG_LEN   = 4;
    localparam int PERIOD_W   = 16;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                stop;
    logic                busy;
    logic                done;
    logic                tone_en;
    logic [PERIOD_W-1:0] tone_period;
    logic                tone_strobe;
    logic [3:0]          note_idx;

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] sbq [$];
    logic [3:0]  last_idx;

    note_sequencer #(
        .BEAT_DIV   (BEAT_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .SONG_LEN   (SONG_LEN),
        .PERIOD_W   (PERIOD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .tone_en     (tone_en),
        .tone_period (tone_period),
        .tone_strobe (tone_strobe),
        .note_idx    (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic b, input logic d, input logic e,
                                       input logic s, input logic [15:0] per,
                                       input logic [3:0] idx);
        return {b, d, e, s, per, idx};
    endfunction

    function automatic logic [23:0] idle_vec(input logic [3:0] idx);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, idx);
    endfunction

    // Expected trace of whole songs starting from IDLE. Slot index 0 is the
    // LOAD cycle (previous outputs held, tone silent); index 1 strobes the
    // new period; tone sounds on indices 1..SLOT-GAP.
    task automatic push_song(input int loops);
        logic [15:0] cur_per;
        logic [3:0]  pv;
        int          slot;
        cur_per = 16'd0;
        for (int l = 0; l < loops; l++) begin
            for (int s = 0; s < SONG_LEN; s++) begin
                pv   = SONG_ROM[s].pitch;
                slot = (int'(SONG_ROM[s].dur) + 1) * BEAT_DIV;
                sbq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, cur_per, last_idx));
                for (int k = 1; k < slot; k++) begin
                    sbq.push_back(mk(1'b1, 1'b0, (pv != 4'd0) && (k <= slot - GAP_CYCLES),
                                     k == 1, PERIOD_LUT[pv], 4'(s)));
                end
                cur_per  = PERIOD_LUT[pv];
                last_idx = 4'(s);
            end
        end
    endtask

    task automatic check_now(input string tag);
        logic [23:0] obs_v;
        logic [23:0] exp_v;
        obs_v = {busy, done, tone_en, tone_strobe, tone_period, note_idx};
        checks++;
        assert (sbq.size() != 0) else begin
            failures++;
            $error("FAIL %s scoreboard empty at t=%0t, got=%h", tag, $time, obs_v);
        end
        if (sbq.size() != 0) begin
            exp_v = sbq.pop_front();
            assert (obs_v === exp_v) else begin
                failures++;
                $error("FAIL %s t=%0t {busy,done,en,stb,period,idx} got=%h required=%h",
                       tag, $time, obs_v, exp_v);
            end
        end
    endtask

    task automatic check_cycle(input string tag);
        @(negedge clk);
        check_now(tag);
    endtask

    task automatic drain(input string tag);
        while (sbq.size() != 0) check_cycle(tag);
    endtask

    task automatic play_full(input string tag);
        start = 1'b1;
`ifdef SEQ_LOOP_EN
        push_song(3);
        check_cycle(tag);
        start = 1'b0;
        drain(tag);
        // Next cycle would reload step 0 of a fourth loop; abort it.
        stop = 1'b1;
        sbq.push_back(idle_vec(last_idx));
        check_cycle({tag, "_stop"});
        stop = 1'b0;
        sbq.push_back(idle_vec(last_idx));
        check_cycle({tag, "_idle"});
`else
        push_song(1);
        sbq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, last_idx));
        sbq.push_back(idle_vec(last_idx));
        sbq.push_back(idle_vec(last_idx));
        check_cycle(tag);
        start = 1'b0;
        drain(tag);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        last_idx = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        sbq.push_back(idle_vec(4'd0));
        check_now("reset");
        rst_n = 1'b1;

        // stop alone, and start together with stop, in IDLE
        stop = 1'b1;
        sbq.push_back(idle_vec(4'd0));
        check_cycle("idle_stop");
        start = 1'b1;
        sbq.push_back(idle_vec(4'd0));
        check_cycle("idle_start_stop");
        start = 1'b0;
        stop  = 1'b0;
        sbq.push_back(idle_vec(4'd0));
        check_cycle("idle_quiet");

        // Full song: note timing, rest slot, song end / looping
        play_full("song");

        // start while busy is ignored; stop+start mid-PLAY aborts
        start = 1'b1;
        push_song(1);
        check_cycle("abort_load");
        start = 1'b0;
        check_cycle("abort_play");
        check_cycle("abort_play");
        start = 1'b1;
        check_cycle("start_busy");
        start = 1'b0;
        check_cycle("start_busy_after");
        stop  = 1'b1;
        start = 1'b1;
        sbq.delete();
        repeat (3) sbq.push_back(idle_vec(4'd0));
        check_cycle("stop_with_start");
        stop  = 1'b0;
        start = 1'b0;
        drain("stop_idle");
        last_idx = 4'd0;

        // Async reset while the tone is sounding
        start = 1'b1;
        push_song(1);
        check_cycle("rst_load");
        start = 1'b0;
        repeat (3) check_cycle("rst_play");
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        sbq.push_back(idle_vec(4'd0));
        check_now("async_rst");
        sbq.push_back(idle_vec(4'd0));
        check_cycle("in_rst");
        rst_n = 1'b1;
        repeat (3) sbq.push_back(idle_vec(4'd0));
        drain("after_rst");
        last_idx = 4'd0;

        // Playback works again after a fresh start
        play_full("replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_note_sequencer
`default_nettype wire
